// File: rtl/mjpeg_pkg.sv
// rtl/mjpeg_pkg.sv - shared MJPEG types, geometry constants and sample helpers
package mjpeg_pkg;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CR = 2'd1,
        COMP_CB = 2'd2
    } comp_e;

    localparam int SAMPLES_PER_VEC = 8;
    localparam int VEC_PER_BLK     = 8;
    localparam int BLK_PER_MCU     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gather_state_e;

    // Blocks 0-3 are luma, 4-5 Cr, 6-7 Cb.
    function automatic comp_e comp_of_blk(input logic [2:0] blk);
        if (!blk[2]) begin
            return COMP_Y;
        end else if (!blk[1]) begin
            return COMP_CR;
        end else begin
            return COMP_CB;
        end
    endfunction

    // Unsigned sample minus 128 is exactly an MSB flip in 8 bits.
    function automatic logic [7:0] level_shift(input logic [7:0] x, input logic en);
        return en ? {~x[7], x[6:0]} : x;
    endfunction

endpackage

// File: rtl/pulse_delay_line.sv
// rtl/pulse_delay_line.sv - fixed-latency delay for a single-bit pulse
module pulse_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0] sr;

            // Shift the pulse one stage per falling edge.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr <= DEPTH'({sr, din});
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ycc_vector_gather.sv
// rtl/ycc_vector_gather.sv - gathers 8-sample level-shifted vectors with MCU tags
module ycc_vector_gather
    import mjpeg_pkg::*;
#(
    parameter int START_LAT   = 2,
    parameter bit LEVEL_SHIFT = 1'b1,
    parameter int VEC_PER_MCU = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        clr,
    input  logic        rd_start,
    input  logic [7:0]  din,
    input  logic        vec_ready,
    output logic        vec_valid,
    output logic [63:0] vec_data,
    output logic [2:0]  vec_idx,
    output logic [2:0]  blk_idx,
    output logic [1:0]  comp,
    output logic        mcu_last,
    output logic        ovf,
    output logic        err_align
);

    localparam int VW       = (VEC_PER_MCU > 1) ? $clog2(VEC_PER_MCU) : 1;
    localparam int VEC_BITS = $clog2(VEC_PER_BLK);
    localparam int BLK_BITS = $clog2(BLK_PER_MCU);
    localparam int TAG_W    = VEC_BITS + BLK_BITS;
    localparam int HOLD_W   = (SAMPLES_PER_VEC - 1) * 8;

    logic                marker;
    gather_state_e       state_q, state_d;
    logic [2:0]          smp_cnt, smp_d;
    logic                cap, complete, misalign;
    logic [2:0]          cap_slot;
    logic [HOLD_W-1:0]   hold;
    logic [63:0]         assembled;
    logic [VW-1:0]       vec_cnt;
    logic [TAG_W-1:0]    tag;

    pulse_delay_line #(
        .DEPTH (START_LAT)
    ) u_marker (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (rd_start),
        .dout  (marker)
    );

    // A marker always lands in slot 0; otherwise fill the running slot.
    assign cap_slot = marker ? 3'd0 : smp_cnt;
    assign tag      = TAG_W'(vec_cnt);

    // Next-state and capture control for the sample-slot sequencer.
    always_comb begin
        state_d  = state_q;
        smp_d    = smp_cnt;
        cap      = 1'b0;
        complete = 1'b0;
        misalign = 1'b0;
        case (state_q)
            IDLE: begin
                if (marker) begin
                    cap     = 1'b1;
                    smp_d   = 3'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (marker) begin
                    cap      = 1'b1;
                    smp_d    = 3'd1;
                    misalign = (smp_cnt != 3'd0);
                end else if (smp_cnt == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cap      = 1'b1;
                    smp_d    = smp_cnt + 3'd1;
                    complete = (smp_cnt == 3'd7);
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d  = IDLE;
            smp_d    = 3'd0;
            cap      = 1'b0;
            complete = 1'b0;
            misalign = 1'b0;
        end
    end

    // Seven held samples plus the live one form the completed vector.
    always_comb begin
        assembled = '0;
        for (int i = 0; i < SAMPLES_PER_VEC - 1; i++) begin
            assembled[i*8 +: 8] = level_shift(hold[i*8 +: 8], LEVEL_SHIFT);
        end
        assembled[63:56] = level_shift(din, LEVEL_SHIFT);
    end

    // Sequencer state register.
    always_ff @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            smp_cnt <= 3'd0;
        end else begin
            state_q <= state_d;
            smp_cnt <= smp_d;
        end
    end

    // Sample slots, output register, vector counter and sticky flags.
    always_ff @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold      <= '0;
            vec_valid <= 1'b0;
            vec_data  <= '0;
            vec_idx   <= '0;
            blk_idx   <= '0;
            comp      <= '0;
            mcu_last  <= 1'b0;
            ovf       <= 1'b0;
            err_align <= 1'b0;
            vec_cnt   <= '0;
        end else if (clr) begin
            hold      <= '0;
            vec_valid <= 1'b0;
            vec_data  <= '0;
            vec_idx   <= '0;
            blk_idx   <= '0;
            comp      <= '0;
            mcu_last  <= 1'b0;
            ovf       <= 1'b0;
            err_align <= 1'b0;
            vec_cnt   <= '0;
        end else begin
            for (int i = 0; i < SAMPLES_PER_VEC - 1; i++) begin
                if (cap && cap_slot == 3'(i)) begin
                    hold[i*8 +: 8] <= din;
                end
            end
            if (misalign) begin
                err_align <= 1'b1;
            end
            if (complete) begin
                vec_data  <= assembled;
                vec_valid <= 1'b1;
                vec_idx   <= tag[VEC_BITS-1:0];
                blk_idx   <= tag[TAG_W-1:VEC_BITS];
                comp      <= comp_of_blk(tag[TAG_W-1:VEC_BITS]);
                mcu_last  <= (vec_cnt == VW'(VEC_PER_MCU - 1));
                vec_cnt   <= vec_cnt + VW'(1);
                if (vec_valid && !vec_ready) begin
                    ovf <= 1'b1;
                end
            end else if (vec_valid && vec_ready) begin
                vec_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ycc_vector_gather.sv
// tb/tb_ycc_vector_gather.sv - scoreboard bench for ycc_vector_gather
module tb_ycc_vector_gather;

    localparam int START_LAT   = 2;
    localparam int VEC_PER_MCU = 64;

    logic        sys_clk, sys_rst_n, clr, rd_start, vec_ready;
    logic [7:0]  din;
    logic        vec_valid, mcu_last, ovf, err_align;
    logic [63:0] vec_data;
    logic [2:0]  vec_idx, blk_idx;
    logic [1:0]  comp;

    int checks   = 0;
    int failures = 0;

    logic [72:0] exp_q[$];
    bit          rs_a[];
    logic [7:0]  din_a[];
    bit          rdy_a[];
    int          n_cyc;

    int          model_vcnt = 0;
    bit          model_ovf  = 1'b0;
    bit          model_err  = 1'b0;

    logic [63:0] last_data = '0;
    logic [2:0]  last_idx  = '0;
    int          last_cnt  = 0;
    logic [72:0] mon_act, mon_exp;

    ycc_vector_gather dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (clr),
        .rd_start  (rd_start),
        .din       (din),
        .vec_ready (vec_ready),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_idx   (vec_idx),
        .blk_idx   (blk_idx),
        .comp      (comp),
        .mcu_last  (mcu_last),
        .ovf       (ovf),
        .err_align (err_align)
    );

    initial begin
        sys_clk = 1'b1;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake happens on the coming falling edge.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (sys_rst_n && !clr && vec_valid && vec_ready) begin
                mon_act = {vec_data, vec_idx, blk_idx, comp, mcu_last};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL vec_unexpected got=%0h expected=none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        failures++;
                        $display("FAIL vec_accept got=%0h expected=%0h", mon_act, mon_exp);
                    end
                end
                last_data = vec_data;
                last_idx  = vec_idx;
                if (mcu_last) last_cnt++;
            end
        end
    end

    task automatic sched_new(input int n);
        n_cyc = n;
        rs_a  = new[n];
        din_a = new[n];
        rdy_a = new[n];
        for (int t = 0; t < n; t++) begin
            rs_a[t]  = 1'b0;
            din_a[t] = 8'($urandom);
            rdy_a[t] = 1'b1;
        end
    endtask

    // Keep the tail quiet so every schedule ends idle with nothing pending.
    task automatic sched_tail();
        for (int t = n_cyc - 12; t < n_cyc; t++) rs_a[t] = 1'b0;
        for (int t = n_cyc - 10; t < n_cyc; t++) rdy_a[t] = 1'b1;
    endtask

    // Reference: every marker opens a vector; it survives if no other
    // marker arrives within its next 7 samples. A completed vector is seen by
    // the consumer if ready is high on some edge after it completes and no
    // later than the next completion.
    task automatic model_schedule();
        int          starts[$];
        bit          broken, acc;
        int          c, lim, blk, cp;
        logic [63:0] d;
        for (int t = START_LAT; t < n_cyc; t++) begin
            if (rs_a[t-START_LAT]) begin
                broken = 1'b0;
                for (int j = 1; j < 8; j++)
                    if (t + j < n_cyc && rs_a[t+j-START_LAT]) broken = 1'b1;
                if (broken) model_err = 1'b1;
                else if (t + 7 < n_cyc) starts.push_back(t);
            end
        end
        for (int k = 0; k < starts.size(); k++) begin
            c   = starts[k] + 7;
            lim = (k + 1 < starts.size()) ? starts[k+1] + 7 : n_cyc - 1;
            acc = 1'b0;
            for (int e = c + 1; e <= lim; e++) if (rdy_a[e]) acc = 1'b1;
            for (int i = 0; i < 8; i++) d[i*8 +: 8] = din_a[starts[k]+i] - 8'd128;
            blk = (model_vcnt / 8) % 8;
            cp  = (blk < 4) ? 0 : (blk < 6) ? 1 : 2;
            if (acc)
                exp_q.push_back({d, 3'(model_vcnt % 8), 3'(blk), 2'(cp),
                                 (model_vcnt % VEC_PER_MCU) == VEC_PER_MCU - 1});
            else if (k + 1 < starts.size())
                model_ovf = 1'b1;
            model_vcnt = (model_vcnt + 1) % VEC_PER_MCU;
        end
    endtask

    task automatic run_schedule(input string name);
        model_schedule();
        for (int t = 0; t < n_cyc; t++) begin
            @(posedge sys_clk);
            rd_start  = rs_a[t];
            din       = din_a[t];
            vec_ready = rdy_a[t];
        end
        @(posedge sys_clk);
        rd_start  = 1'b0;
        vec_ready = 1'b0;
        din       = 8'h00;
        #2;
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_ovf"}, 64'(ovf), 64'(model_ovf));
        check({name, "_err_align"}, 64'(err_align), 64'(model_err));
        exp_q.delete();
    endtask

    task automatic pulse_clr();
        @(posedge sys_clk);
        clr = 1'b1;
        @(posedge sys_clk);
        clr = 1'b0;
        model_vcnt = 0;
        model_ovf  = 1'b0;
        model_err  = 1'b0;
    endtask

    task automatic sched_single();
        sched_new(24);
        rs_a[0] = 1'b1;
        for (int i = 0; i < 8; i++) din_a[2+i] = 8'h80 + 8'(i);
    endtask

    // Abort a vector at smp_cnt==5 by clr or by reset.
    task automatic mid_clear(input bit use_rst, input string name);
        @(posedge sys_clk);
        rd_start = 1'b1;
        din      = 8'($urandom);
        for (int t = 1; t < 8; t++) begin
            @(posedge sys_clk);
            rd_start = 1'b0;
            din      = 8'($urandom);
            if (t == 7) begin
                if (use_rst) sys_rst_n = 1'b0;
                else clr = 1'b1;
            end
        end
        @(posedge sys_clk);
        clr       = 1'b0;
        sys_rst_n = 1'b1;
        #1;
        check({name, "_outputs_zero"},
              64'({vec_valid, vec_idx, blk_idx, comp, mcu_last, ovf, err_align}), 64'd0);
        check({name, "_data_zero"}, vec_data, 64'd0);
        model_vcnt = 0;
        model_ovf  = 1'b0;
        model_err  = 1'b0;
        repeat (4) @(posedge sys_clk);
        sched_single();
        run_schedule({name, "_next_vec"});
        check({name, "_next_idx"}, 64'(last_idx), 64'd0);
        check({name, "_next_data"}, last_data, 64'h0706050403020100);
    endtask

    initial begin
        int lc0;
        sys_rst_n = 1'b0;
        clr       = 1'b0;
        rd_start  = 1'b0;
        din       = 8'h00;
        vec_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_flags", 64'({vec_valid, vec_idx, blk_idx, comp, mcu_last, ovf, err_align}), 64'd0);
        check("reset_data", vec_data, 64'd0);
        @(posedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        // Single vector.
        sched_single();
        run_schedule("single");
        check("single_data", last_data, 64'h0706050403020100);
        check("single_idx", 64'(last_idx), 64'd0);

        // Full MCU, back-to-back, then wrap.
        pulse_clr();
        sched_new(528);
        for (int k = 0; k < 64; k++) rs_a[8*k] = 1'b1;
        for (int t = 0; t < 528; t++) din_a[t] = 8'hFF;
        sched_tail();
        lc0 = last_cnt;
        run_schedule("full_mcu");
        check("full_mcu_last_count", 64'(last_cnt - lc0), 64'd1);
        check("full_mcu_lane", last_data, {8{8'h7F}});
        sched_single();
        run_schedule("wrap");
        check("wrap_idx", 64'(last_idx), 64'd0);

        // Back-pressure across two completions.
        sched_new(40);
        rs_a[0] = 1'b1;
        rs_a[8] = 1'b1;
        for (int t = 0; t < 20; t++) rdy_a[t] = 1'b0;
        sched_tail();
        run_schedule("overrun");
        sched_single();
        run_schedule("ovf_sticky");

        // Marker lands at smp_cnt==3.
        pulse_clr();
        sched_new(30);
        rs_a[0] = 1'b1;
        rs_a[3] = 1'b1;
        sched_tail();
        run_schedule("misalign");
        check("misalign_idx", 64'(last_idx), 64'd0);

        // Consumer accepts exactly on the reload edges.
        pulse_clr();
        sched_new(46);
        for (int k = 0; k < 4; k++) rs_a[8*k] = 1'b1;
        for (int t = 0; t < 46; t++) rdy_a[t] = 1'b0;
        for (int k = 0; k < 4; k++) rdy_a[8*k+9] = 1'b1;
        sched_tail();
        run_schedule("accept_reload");

        // Randomised streams.
        for (int r = 0; r < 3; r++) begin
            sched_new(400);
            for (int t = 0; t < 400; t++) begin
                rs_a[t]  = ($urandom_range(0, 5) == 0);
                rdy_a[t] = ($urandom_range(0, 3) > r);
            end
            sched_tail();
            run_schedule("random");
        end
        sched_new(300);
        for (int t = 0; t < 300; t += 8) rs_a[t] = 1'b1;
        for (int t = 0; t < 300; t++) rdy_a[t] = ($urandom_range(0, 7) == 0);
        sched_tail();
        run_schedule("random_aligned");

        mid_clear(1'b0, "mid_clr");
        mid_clear(1'b1, "mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
